// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package addsub_pkg;

  // Status reported alongside every result beat.
  typedef struct packed {
    logic cout;  // carry out of MSB (for subtract: 1 = no borrow)
    logic ovf;   // signed overflow
    logic zero;  // result is all zeros
    logic neg;   // result MSB
  } addsub_flags_t;

  localparam int unsigned ADDSUB_FLAGS_W = $bits(addsub_flags_t);

  // Slicing only works when the operand splits into equal, non-empty slices.
  function automatic bit addsub_params_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit ripple-carry slice built from full-adder cells.
// Also exposes the carry into the slice MSB so the final stage can derive
// signed overflow without re-adding anything.
module addsub_slice #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);
  import addsub_pkg::*;

  logic [SW:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < SW; gi++) begin : g_fa
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout     = c[SW];
  assign c_msb_in = c[SW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshakes.
// Stage 0 is the combinational input side; stage k (k >= 1) is a register
// holding result slices 0..k-1, the pending carry and the operand slices
// still to be summed. The final slice feeds the registered output, so a
// beat accepted in cycle t is presented in cycle t+STAGES. The whole pipe
// advances as one unit whenever the output is empty or being consumed.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  import addsub_pkg::*;

  localparam int unsigned SW = WIDTH / STAGES;

  if (!addsub_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("addsub_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Per-stage view: what enters the slice adder of stage k.
  logic             v_in    [STAGES];
  logic             c_in    [STAGES];
  logic [WIDTH-1:0] word_in [STAGES];  // result slices below k, A slices from k up
  logic [WIDTH-1:0] b_in    [STAGES];  // pending (possibly inverted) B slices, LSB-aligned
  // Per-stage slice results.
  logic             c_out   [STAGES];
  logic             c_msb   [STAGES];
  logic [WIDTH-1:0] word_out[STAGES];

  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  addsub_flags_t    flags_q, flags_d;

  // A single global enable: hold everything while a result waits on the consumer.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Width of the B slices still waiting when this stage is entered.
    localparam int unsigned BW = (STAGES - gi) * SW;
    // Bits of the word that this stage's slice replaces with its sum.
    localparam logic [WIDTH-1:0] SMASK =
      ((WIDTH'(1) << SW) - WIDTH'(1)) << (gi * SW);

    logic [SW-1:0] slice_s;

    if (gi == 0) begin : g_in
      // Subtraction is A + ~B + 1: invert B up front and seed the carry.
      assign v_in[gi]    = in_valid;
      assign c_in[gi]    = sub;
      assign word_in[gi] = A;
      assign b_in[gi]    = B ^ {WIDTH{sub}};
    end else begin : g_reg
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] word_q;
      logic [BW-1:0]    b_q;

      // Stage register: capture the previous slice's sum/carry and drop its consumed B slice.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q    <= 1'b0;
          c_q    <= 1'b0;
          word_q <= '0;
          b_q    <= '0;
        end else if (advance) begin
          v_q    <= v_in[gi-1];
          c_q    <= c_out[gi-1];
          word_q <= word_out[gi-1];
          b_q    <= b_in[gi-1][SW +: BW];
        end
      end

      assign v_in[gi]    = v_q;
      assign c_in[gi]    = c_q;
      assign word_in[gi] = word_q;
      assign b_in[gi]    = {{(WIDTH-BW){1'b0}}, b_q};
    end

    addsub_slice #(
      .SW(SW)
    ) u_slice (
      .a        (word_in[gi][gi*SW +: SW]),
      .b        (b_in[gi][SW-1:0]),
      .cin      (c_in[gi]),
      .s        (slice_s),
      .cout     (c_out[gi]),
      .c_msb_in (c_msb[gi])
    );

    assign word_out[gi] = (word_in[gi] & ~SMASK) | (WIDTH'(slice_s) << (gi * SW));
  end

  assign sum_d = word_out[STAGES-1];

  // Status flags derived from the completed sum and the final slice's carries.
  always_comb begin
    flags_d      = '0;
    flags_d.cout = c_out[STAGES-1];
    flags_d.ovf  = c_out[STAGES-1] ^ c_msb[STAGES-1];
    flags_d.zero = (sum_d == '0);
    flags_d.neg  = sum_d[WIDTH-1];
  end

  // Output register: only rewritten on advance, and only when a real beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      out_valid_q <= v_in[STAGES-1];
      if (v_in[STAGES-1]) begin
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: the driver pushes reference results
// computed with plain integer arithmetic; a negedge monitor pops and
// compares every transferred result, including its arrival cycle.
module tb_addsub_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero, neg;

  always #5 clk = ~clk;

  addsub_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;
  int   n_out     = 0;
  logic rand_rdy  = 1'b0;
  logic hold_rdy  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the operand values, signed range test for overflow.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t        e;
    int unsigned ua = a;
    int unsigned ub = b;
    int          sa = $signed(a);
    int          sbv = $signed(b);
    int          r;
    if (s) begin
      e.sum  = 16'(ua - ub);
      e.cout = (ua >= ub);
      r      = sa - sbv;
    end else begin
      e.sum  = 16'(ua + ub);
      e.cout = ((ua + ub) > 32'd65535);
      r      = sa + sbv;
    end
    e.ovf       = (r > 32767) || (r < -32768);
    e.zero      = (e.sum == 16'h0000);
    e.neg       = e.sum[15];
    e.acc_cyc   = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer model: random or directed out_ready, changed just after the edge.
  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else          out_ready = hold_rdy;
  end

  // Monitor: handshake rule, stall stability, and scoreboard compare on transfer.
  exp_t        mon_e;
  logic        held = 1'b0;
  logic [15:0] held_sum;
  logic [3:0]  held_flags;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (held) begin
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_sum", {16'b0, sum}, {16'b0, held_sum});
        chk("stall_flags", {28'b0, cout, ovf, zero, neg}, {28'b0, held_flags});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: sum=0x%04h appeared with empty scoreboard", sum);
        end else begin
          mon_e = sb.pop_front();
          $display("out %0d: sum=0x%04h cout=%b ovf=%b zero=%b neg=%b", n_out, sum, cout, ovf, zero, neg);
          chk("sum", {16'b0, sum}, {16'b0, mon_e.sum});
          chk("flags", {28'b0, cout, ovf, zero, neg},
              {28'b0, mon_e.cout, mon_e.ovf, mon_e.zero, mon_e.neg});
          chk("latency", cyc - mon_e.acc_cyc, STAGES + stall_cnt - mon_e.acc_stall);
          n_out++;
        end
      end
      held       = out_valid && !out_ready;
      held_sum   = sum;
      held_flags = {cout, ovf, zero, neg};
      if (held) stall_cnt++;
    end
  end

  // Drive one beat starting just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int   waited = 0;
    A = a; B = b; sub = s; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e           = model(a, b, s);
        e.acc_cyc   = cyc;
        e.acc_stall = stall_cnt;
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    int ghosts;

    // Reset with a beat offered: nothing may enter, outputs at reset values.
    rst = 1'b1; in_valid = 1'b1; A = 16'h1234; B = 16'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_flags", {28'b0, cout, ovf, zero, neg}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;

    // Directed corner cases.
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h0005, 16'h0005, 1'b1);
    send(16'h0003, 16'h0005, 1'b1);
    drain();

    // Streaming: A=i, B=0xFFFF back to back.
    for (int i = 0; i < 8; i++) send(16'(i), 16'hFFFF, 1'b0);
    drain();

    // Backpressure: hold the consumer off while results are pending.
    hold_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(16'(16'h1000 + i), 16'h0234, 1'(i & 1));
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      if (k < 2) @(negedge clk);
    end
    @(posedge clk);
    #1;
    hold_rdy = 1'b1;
    drain();

    // Reset with three beats in flight: outputs clear at once, nothing emerges.
    for (int i = 0; i < 3; i++) send(16'(16'h0100 * (i + 1)), 16'h0011, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_sum", {16'b0, sum}, 32'd0);
    chk("midrst_flags", {28'b0, cout, ovf, zero, neg}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ghosts = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    chk("midrst_no_ghost", ghosts, 32'd0);
    @(posedge clk);
    #1;
    send(16'hABCD, 16'h1234, 1'b1);
    drain();

    // Randomized traffic with random idle gaps and random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_rdy = 1'b0;
    hold_rdy = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
